// File: rtl/si3000_pkg.sv
// Shared types and secondary-word field layout for the Si3000 codec-side emulator.
package si3000_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PRI,
      S_GAP,
      S_SEC
   } state_t;

   localparam int unsigned SEC_RW_BIT   = 13;
   localparam int unsigned SEC_ADDR_MSB = 12;
   localparam int unsigned SEC_ADDR_LSB = 8;
   localparam int unsigned SEC_DATA_MSB = 7;
   localparam int unsigned SEC_DATA_LSB = 0;

   localparam int unsigned REG_COUNT  = 32;
   localparam int unsigned REG_ADDR_W = $clog2(REG_COUNT);
   localparam int unsigned REG_DATA_W = 8;

endpackage

// File: rtl/si3000_sclk_gen.sv
// SCLK divider: toggles SCLK every SCLK_DIV clks and flags the clk before each edge.
module si3000_sclk_gen #(
   parameter int unsigned SCLK_DIV = 8
) (
   input  logic clk,
   input  logic reset_n,
   input  logic sync_reset,
   output logic sclk,
   output logic rise_tick_c,
   output logic fall_tick_c
);

   localparam int unsigned CNT_W = $clog2(SCLK_DIV);

   logic [CNT_W-1:0] cnt;
   logic             last_c;

   // Ticks lead the SCLK edge by one clk so pin updates land on the same edge.
   assign last_c      = (cnt == CNT_W'(SCLK_DIV - 1));
   assign rise_tick_c = last_c && !sclk;
   assign fall_tick_c = last_c && sclk;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt  <= '0;
         sclk <= 1'b0;
      end else if (sync_reset) begin
         cnt  <= '0;
         sclk <= 1'b0;
      end else if (last_c) begin
         cnt  <= '0;
         sclk <= ~sclk;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/si3000_codec_emu.sv
// Codec side of the Si3000 serial port (DIM 0): frame generation, sample shifting
// and secondary-frame access to a 32x8 control register file.
module si3000_codec_emu
   import si3000_pkg::*;
#(
   parameter int unsigned SCLK_DIV    = 8,
   parameter int unsigned FRAME_SCLKS = 128,
   parameter int unsigned WORD_SIZE   = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  sync_reset,
   input  logic                  enable,
   input  logic [WORD_SIZE-1:0]  tx_sample,
   output logic                  tx_grasp,
   output logic [WORD_SIZE-1:0]  rx_sample,
   output logic                  rx_valid,
   output logic                  ctrl_wr,
   output logic [REG_ADDR_W-1:0] ctrl_addr,
   output logic [REG_DATA_W-1:0] ctrl_data,
   output logic                  Si3000_SCLK,
   output logic                  Si3000_FSYNC_N,
   output logic                  Si3000_SDO,
   input  logic                  Si3000_SDI
);

   localparam int unsigned POS_W     = $clog2(FRAME_SCLKS + 1);
   localparam int unsigned BIT_W     = $clog2(WORD_SIZE);
   localparam int unsigned HALF_BITS = WORD_SIZE / 2;

   logic                  rise_tick_c;
   logic                  fall_tick_c;
   logic [1:0]            sdi_sync;
   state_t                state;
   logic [POS_W-1:0]      pos;
   logic [BIT_W-1:0]      bit_cnt;
   logic [WORD_SIZE-1:0]  tx_shift;
   logic [WORD_SIZE-1:0]  rx_shift;
   logic                  sec_req;
   logic [REG_DATA_W-1:0] regs [REG_COUNT];

   logic [WORD_SIZE-1:0]  rx_next_c;
   logic [POS_W-1:0]      pos_next_c;
   logic [REG_ADDR_W-1:0] mid_addr_c;
   logic [REG_ADDR_W-1:0] sec_addr_c;
   logic [REG_DATA_W-1:0] sec_data_c;
   logic                  wrap_c;
   logic                  start_pri_c;

   si3000_sclk_gen #(.SCLK_DIV(SCLK_DIV)) u_sclk_gen (
      .clk         (clk),
      .reset_n     (reset_n),
      .sync_reset  (sync_reset),
      .sclk        (Si3000_SCLK),
      .rise_tick_c (rise_tick_c),
      .fall_tick_c (fall_tick_c)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sdi_sync <= '0;
      else          sdi_sync <= {sdi_sync[0], Si3000_SDI};
   end

   // After the 8th fall only the upper byte is in, so the address sits HALF_BITS lower.
   assign rx_next_c   = {rx_shift[WORD_SIZE-2:0], sdi_sync[1]};
   assign pos_next_c  = pos + 1'b1;
   assign mid_addr_c  = rx_next_c[SEC_ADDR_MSB-HALF_BITS:SEC_ADDR_LSB-HALF_BITS];
   assign sec_addr_c  = rx_next_c[SEC_ADDR_MSB:SEC_ADDR_LSB];
   assign sec_data_c  = rx_next_c[SEC_DATA_MSB:SEC_DATA_LSB];
   assign wrap_c      = (state == S_GAP) && (pos_next_c == POS_W'(FRAME_SCLKS));
   assign start_pri_c = rise_tick_c && enable && ((state == S_IDLE) || wrap_c);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= S_IDLE;
         pos            <= '0;
         bit_cnt        <= '0;
         tx_shift       <= '0;
         rx_shift       <= '0;
         sec_req        <= 1'b0;
         tx_grasp       <= 1'b0;
         rx_valid       <= 1'b0;
         ctrl_wr        <= 1'b0;
         rx_sample      <= '0;
         ctrl_addr      <= '0;
         ctrl_data      <= '0;
         Si3000_FSYNC_N <= 1'b1;
         Si3000_SDO     <= 1'b0;
         for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      end else if (sync_reset) begin
         state          <= S_IDLE;
         pos            <= '0;
         bit_cnt        <= '0;
         tx_shift       <= '0;
         rx_shift       <= '0;
         sec_req        <= 1'b0;
         tx_grasp       <= 1'b0;
         rx_valid       <= 1'b0;
         ctrl_wr        <= 1'b0;
         Si3000_FSYNC_N <= 1'b1;
         Si3000_SDO     <= 1'b0;
      end else begin
         tx_grasp <= 1'b0;
         rx_valid <= 1'b0;
         ctrl_wr  <= 1'b0;
         if (start_pri_c) begin
            state          <= S_PRI;
            pos            <= '0;
            bit_cnt        <= '0;
            tx_shift       <= {tx_sample[WORD_SIZE-2:0], 1'b0};
            tx_grasp       <= 1'b1;
            Si3000_FSYNC_N <= 1'b0;
            Si3000_SDO     <= tx_sample[WORD_SIZE-1];
         end else begin
            case (state)
               S_PRI, S_SEC: begin
                  if (rise_tick_c) begin
                     pos        <= pos_next_c;
                     Si3000_SDO <= tx_shift[WORD_SIZE-1];
                     tx_shift   <= {tx_shift[WORD_SIZE-2:0], 1'b0};
                  end
                  if (fall_tick_c) begin
                     rx_shift <= rx_next_c;
                     bit_cnt  <= bit_cnt + 1'b1;
                     // Register contents replace the still-unsent low byte of the reply.
                     if (state == S_SEC && bit_cnt == BIT_W'(HALF_BITS - 1))
                        tx_shift[WORD_SIZE-1 -: REG_DATA_W] <= regs[mid_addr_c];
                     if (bit_cnt == BIT_W'(WORD_SIZE - 1)) begin
                        state <= S_GAP;
                        if (state == S_PRI) begin
                           rx_sample <= rx_next_c;
                           rx_valid  <= 1'b1;
                           sec_req   <= rx_next_c[0];
                        end else begin
                           sec_req   <= 1'b0;
                           ctrl_addr <= sec_addr_c;
                           if (rx_next_c[SEC_RW_BIT]) begin
                              ctrl_data <= regs[sec_addr_c];
                           end else begin
                              regs[sec_addr_c] <= sec_data_c;
                              ctrl_data        <= sec_data_c;
                              ctrl_wr          <= 1'b1;
                           end
                        end
                     end
                  end
               end
               S_GAP: begin
                  if (rise_tick_c) begin
                     pos            <= pos_next_c;
                     Si3000_FSYNC_N <= 1'b1;
                     Si3000_SDO     <= 1'b0;
                     if (wrap_c) begin
                        state <= S_IDLE;
                        pos   <= '0;
                     end else if (pos_next_c == POS_W'(FRAME_SCLKS / 2) && sec_req) begin
                        state          <= S_SEC;
                        bit_cnt        <= '0;
                        tx_shift       <= '0;
                        Si3000_FSYNC_N <= 1'b0;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_si3000_codec_emu.sv
// Bench for si3000_codec_emu: a behavioural host shifts frames against a scoreboard.
module tb_si3000_codec_emu;

   localparam int unsigned SCLK_DIV    = 8;
   localparam int unsigned FRAME_SCLKS = 128;
   localparam int unsigned FRAME_CLKS  = FRAME_SCLKS * 2 * SCLK_DIV;
   localparam int unsigned HALF_CLKS   = FRAME_SCLKS * SCLK_DIV;

   typedef struct packed {
      logic        is_sec;
      logic [15:0] sdi;
      logic [15:0] sdo;
      logic        rd;
      logic [4:0]  addr;
      logic [7:0]  data;
   } frame_t;

   logic        clk;
   logic        reset_n;
   logic        sync_reset;
   logic        enable;
   logic [15:0] tx_sample;
   logic        tx_grasp;
   logic [15:0] rx_sample;
   logic        rx_valid;
   logic        ctrl_wr;
   logic [4:0]  ctrl_addr;
   logic [7:0]  ctrl_data;
   logic        sclk;
   logic        fsync_n;
   logic        sdo;
   logic        sdi;

   si3000_codec_emu #(
      .SCLK_DIV    (SCLK_DIV),
      .FRAME_SCLKS (FRAME_SCLKS),
      .WORD_SIZE   (16)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .sync_reset     (sync_reset),
      .enable         (enable),
      .tx_sample      (tx_sample),
      .tx_grasp       (tx_grasp),
      .rx_sample      (rx_sample),
      .rx_valid       (rx_valid),
      .ctrl_wr        (ctrl_wr),
      .ctrl_addr      (ctrl_addr),
      .ctrl_data      (ctrl_data),
      .Si3000_SCLK    (sclk),
      .Si3000_FSYNC_N (fsync_n),
      .Si3000_SDO     (sdo),
      .Si3000_SDI     (sdi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks = 0;
   int          fails = 0;
   longint      cyc = 0;
   logic        sclk_p = 1'b0;
   logic        fsync_p = 1'b1;
   logic        in_frame = 1'b0;
   int          bit_idx = 0;
   int          rise_idx = 0;
   logic [15:0] cur_rx = '0;
   frame_t      cur = '0;
   frame_t      exp_q[$];
   int          frames_done = 0;
   int          falls = 0;
   int          grasp_cnt = 0;
   int          rx_valid_cnt = 0;
   int          ctrl_wr_cnt = 0;
   longint      last_pri_fall = 0;
   longint      prev_pri_fall = 0;
   longint      last_sec_fall = 0;
   logic [7:0]  reg_m [32];

   // One clk of host behaviour; outputs are sampled on the falling clk edge.
   task automatic step();
      logic [15:0] w;
      @(negedge clk);
      cyc++;
      if (tx_grasp) grasp_cnt++;
      if (rx_valid) rx_valid_cnt++;
      if (ctrl_wr)  ctrl_wr_cnt++;
      if (in_frame && fsync_n && bit_idx < 16) in_frame = 1'b0;
      if (!fsync_n && fsync_p) begin
         falls++;
         checks++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_frame: FSYNC_N fell at cycle %0d with no frame expected", cyc);
            cur = '0;
         end else begin
            cur = exp_q.pop_front();
         end
         checks++;
         if (tx_grasp !== !cur.is_sec) begin
            fails++;
            $display("FAIL grasp_at_fsync: tx_grasp=%b required=%b (sec=%b)", tx_grasp, !cur.is_sec, cur.is_sec);
         end
         if (cur.is_sec) last_sec_fall = cyc;
         else begin
            prev_pri_fall = last_pri_fall;
            last_pri_fall = cyc;
         end
         in_frame = 1'b1;
         bit_idx  = 0;
         rise_idx = 0;
         cur_rx   = '0;
      end
      if (sclk && !sclk_p && in_frame) begin
         w   = cur.sdi;
         sdi = w[4'(15 - bit_idx)];
         rise_idx++;
      end
      if (!sclk && sclk_p && in_frame) begin
         cur_rx = {cur_rx[14:0], sdo};
         bit_idx++;
         if (bit_idx == 16) begin
            in_frame = 1'b0;
            frames_done++;
            checks++;
            if (cur_rx !== cur.sdo) begin
               fails++;
               $display("FAIL sdo_word: host read %h required %h (sec=%b)", cur_rx, cur.sdo, cur.is_sec);
            end
            checks++;
            if (!cur.is_sec) begin
               if (rx_valid !== 1'b1 || rx_sample !== cur.sdi) begin
                  fails++;
                  $display("FAIL rx_sample: rx_valid=%b rx_sample=%h required 1/%h", rx_valid, rx_sample, cur.sdi);
               end
            end else if (ctrl_wr !== !cur.rd || ctrl_addr !== cur.addr || ctrl_data !== cur.data) begin
               fails++;
               $display("FAIL ctrl_access: wr=%b addr=%h data=%h required %b/%h/%h",
                        ctrl_wr, ctrl_addr, ctrl_data, !cur.rd, cur.addr, cur.data);
            end
         end
      end
      sclk_p  = sclk;
      fsync_p = fsync_n;
   endtask

   task automatic push_pri(input logic [15:0] tx, input logic [15:0] word);
      frame_t f;
      f     = '0;
      f.sdi = word;
      f.sdo = tx;
      exp_q.push_back(f);
   endtask

   task automatic push_sec(input logic [15:0] word);
      frame_t f;
      f        = '0;
      f.is_sec = 1'b1;
      f.sdi    = word;
      f.rd     = word[13];
      f.addr   = word[12:8];
      f.sdo    = {8'h00, reg_m[f.addr]};
      if (f.rd) f.data = reg_m[f.addr];
      else begin
         f.data         = word[7:0];
         reg_m[f.addr]  = word[7:0];
      end
      exp_q.push_back(f);
   endtask

   task automatic wait_frames(input int n);
      int target;
      int budget;
      target = frames_done + n;
      budget = (n + 1) * int'(FRAME_CLKS);
      while (frames_done < target && budget > 0) begin
         step();
         budget--;
      end
      checks++;
      if (frames_done < target) begin
         fails++;
         $display("FAIL frame_timeout: frames_done=%0d required %0d", frames_done, target);
      end
   endtask

   // Enable for exactly one primary frame, let any secondary run, then confirm idle.
   task automatic run_frames(input int n);
      int f0;
      enable = 1'b1;
      wait_frames(1);
      enable = 1'b0;
      if (n > 1) wait_frames(n - 1);
      f0 = falls;
      repeat (FRAME_CLKS + 256) step();
      checks++;
      if (falls !== f0 || exp_q.size() != 0) begin
         fails++;
         $display("FAIL idle_after_frame: extra falls=%0d pending=%0d required 0/0", falls - f0, exp_q.size());
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (5) step();
      checks++;
      if ({sclk, fsync_n, sdo} !== 3'b010) begin
         fails++;
         $display("FAIL reset_pins: sclk/fsync_n/sdo=%b required 010", {sclk, fsync_n, sdo});
      end
      checks++;
      if ({tx_grasp, rx_valid, ctrl_wr} !== 3'b000) begin
         fails++;
         $display("FAIL reset_pulses: grasp/rx_valid/ctrl_wr=%b required 000", {tx_grasp, rx_valid, ctrl_wr});
      end
      checks++;
      if (rx_sample !== 16'h0 || ctrl_addr !== 5'h0 || ctrl_data !== 8'h0) begin
         fails++;
         $display("FAIL reset_data: rx_sample=%h ctrl_addr=%h ctrl_data=%h required 0", rx_sample, ctrl_addr, ctrl_data);
      end
      reset_n = 1'b1;
      repeat (200) step();
      checks++;
      if (fsync_n !== 1'b1 || falls !== 0) begin
         fails++;
         $display("FAIL idle_disabled: fsync_n=%b falls=%0d required 1/0", fsync_n, falls);
      end
   endtask

   task automatic test_loopback();
      int rv0;
      int f0;
      rv0 = rx_valid_cnt;
      f0  = falls;
      tx_sample = 16'hA5C3;
      push_pri(16'hA5C3, 16'h1234);
      run_frames(1);
      checks++;
      if (rx_valid_cnt - rv0 !== 1 || falls - f0 !== 1) begin
         fails++;
         $display("FAIL loopback_counts: rx_valid=%0d falls=%0d required 1/1", rx_valid_cnt - rv0, falls - f0);
      end
   endtask

   task automatic test_sec_write();
      int cw0;
      cw0 = ctrl_wr_cnt;
      tx_sample = 16'h0F0F;
      push_pri(16'h0F0F, 16'h0001);
      push_sec(16'h0512);
      run_frames(2);
      checks++;
      if (last_sec_fall - last_pri_fall !== longint'(HALF_CLKS)) begin
         fails++;
         $display("FAIL sec_offset: %0d clks required %0d", last_sec_fall - last_pri_fall, HALF_CLKS);
      end
      checks++;
      if (ctrl_wr_cnt - cw0 !== 1) begin
         fails++;
         $display("FAIL sec_write_pulses: %0d required 1", ctrl_wr_cnt - cw0);
      end
   endtask

   task automatic test_sec_read();
      int cw0;
      cw0 = ctrl_wr_cnt;
      push_pri(16'h0F0F, 16'h0001);
      push_sec(16'h2500);
      run_frames(2);
      checks++;
      if (ctrl_wr_cnt !== cw0) begin
         fails++;
         $display("FAIL sec_read_no_wr: ctrl_wr pulses=%0d required 0", ctrl_wr_cnt - cw0);
      end
   endtask

   task automatic test_back_to_back();
      int g0;
      int f0;
      g0 = grasp_cnt;
      tx_sample = 16'h3C5A;
      push_pri(16'h3C5A, 16'h1110);
      push_pri(16'h3C5A, 16'h2220);
      push_pri(16'h3C5A, 16'h4440);
      enable = 1'b1;
      wait_frames(1);
      for (int i = 0; i < 2; i++) begin
         wait_frames(1);
         checks++;
         if (last_pri_fall - prev_pri_fall !== longint'(FRAME_CLKS)) begin
            fails++;
            $display("FAIL frame_period: %0d clks required %0d", last_pri_fall - prev_pri_fall, FRAME_CLKS);
         end
      end
      enable = 1'b0;
      f0 = falls;
      repeat (FRAME_CLKS + 256) step();
      checks++;
      if (grasp_cnt - g0 !== 3 || falls !== f0) begin
         fails++;
         $display("FAIL pacing_stop: grasps=%0d extra falls=%0d required 3/0", grasp_cnt - g0, falls - f0);
      end
   endtask

   task automatic test_sync_reset();
      int rv0;
      int f0;
      int budget;
      rv0 = rx_valid_cnt;
      tx_sample = 16'h1357;
      push_pri(16'h1357, 16'h0F0E);
      enable = 1'b1;
      budget = int'(FRAME_CLKS);
      while (!(in_frame && rise_idx == 7) && budget > 0) begin
         step();
         budget--;
      end
      checks++;
      if (budget == 0) begin
         fails++;
         $display("FAIL sync_reset_setup: 7th SCLK of primary frame not seen");
      end
      sync_reset = 1'b1;
      enable     = 1'b0;
      step();
      sync_reset = 1'b0;
      checks++;
      if ({sclk, fsync_n, sdo} !== 3'b010) begin
         fails++;
         $display("FAIL sync_reset_pins: sclk/fsync_n/sdo=%b required 010", {sclk, fsync_n, sdo});
      end
      f0 = falls;
      repeat (40 * 2 * SCLK_DIV) step();
      checks++;
      if (rx_valid_cnt !== rv0 || falls !== f0) begin
         fails++;
         $display("FAIL sync_reset_abort: rx_valid=%0d falls=%0d required 0/0", rx_valid_cnt - rv0, falls - f0);
      end
      tx_sample = 16'h2468;
      push_pri(16'h2468, 16'h0001);
      push_sec(16'h2500);
      run_frames(2);
   endtask

   task automatic test_reset_n_mid_sec();
      int budget;
      tx_sample = 16'h9ABC;
      push_pri(16'h9ABC, 16'h0001);
      push_sec(16'h2500);
      enable = 1'b1;
      wait_frames(1);
      enable = 1'b0;
      budget = int'(FRAME_CLKS);
      while (!(in_frame && cur.is_sec && rise_idx == 5) && budget > 0) begin
         step();
         budget--;
      end
      checks++;
      if (budget == 0) begin
         fails++;
         $display("FAIL reset_n_setup: secondary frame not seen");
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if ({sclk, fsync_n, sdo, tx_grasp, rx_valid, ctrl_wr} !== 6'b010000) begin
         fails++;
         $display("FAIL reset_n_pins: sclk/fsync_n/sdo/grasp/rxv/wr=%b required 010000",
                  {sclk, fsync_n, sdo, tx_grasp, rx_valid, ctrl_wr});
      end
      checks++;
      if (rx_sample !== 16'h0 || ctrl_addr !== 5'h0 || ctrl_data !== 8'h0) begin
         fails++;
         $display("FAIL reset_n_data: rx_sample=%h ctrl_addr=%h ctrl_data=%h required 0", rx_sample, ctrl_addr, ctrl_data);
      end
      repeat (3) step();
      reset_n = 1'b1;
      exp_q.delete();
      for (int i = 0; i < 32; i++) reg_m[i] = 8'h00;
      push_pri(16'h9ABC, 16'h0001);
      push_sec(16'h2500);
      run_frames(2);
   endtask

   initial begin
      reset_n    = 1'b0;
      sync_reset = 1'b0;
      enable     = 1'b0;
      tx_sample  = 16'h0;
      sdi        = 1'b0;
      for (int i = 0; i < 32; i++) reg_m[i] = 8'h00;
      test_reset();
      test_loopback();
      test_sec_write();
      test_sec_read();
      test_back_to_back();
      test_sync_reset();
      test_reset_n_mid_sec();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/si3000_codec_emu.md
# si3000_codec_emu

Synthesizable model of the codec side of the Si3000 serial port, digital interface mode 0. It generates SCLK and FSYNC_N and shifts ADC samples out on SDO. It captures DAC words from SDI and services secondary-frame control-register reads and writes from a 32x8 register file. It connects pin-for-pin to the existing Si3000 host core, for FPGA loopback, board-less bring-up and host-core verification.

## Interface
- SCLK_DIV, 8: clk cycles per SCLK half-period; legal range 8..255.
- FRAME_SCLKS, 128: SCLK periods from one primary FSYNC_N fall to the next; must be even and ≥ 4*(WORD_SIZE+2).
- WORD_SIZE, 16: bits per frame word; fixed at 16 in this revision.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- sync_reset  in  1  synchronous reset of the FSM, counters and pins; register file is kept.
- enable  in  1  run frames; when low, the block stays idle after the current frame.
- tx_sample  in  16  ADC word sent on SDO in the next primary frame.
- tx_grasp  out  1  one-clk pulse when tx_sample is latched.
- rx_sample  out  16  last primary-frame SDI word.
- rx_valid  out  1  one-clk pulse when rx_sample updates.
- ctrl_wr  out  1  one-clk pulse on a secondary-frame register write.
- ctrl_addr  out  5  address of the last secondary access.
- ctrl_data  out  8  data written (write) or returned (read).
- Si3000_SCLK  out  1  serial clock.
- Si3000_FSYNC_N  out  1  frame sync, active low.
- Si3000_SDO  out  1  codec to host data.
- Si3000_SDI  in  1  host to codec data; asynchronous.

## Operation
- SDI passes through a 2-FF synchronizer.
- The divider toggles SCLK every SCLK_DIV clks and produces internal rise_tick and fall_tick.
- All pin outputs change only on rise_tick. SDI is sampled only on fall_tick.
- FSM states:
  - S_IDLE: leave on rise_tick when enable=1 -> S_PRI. tx_sample is latched into the shift register and tx_grasp pulses.
  - S_PRI: FSYNC_N=0 for WORD_SIZE SCLK periods.
    - SDO drives the shift register MSB first, advancing one bit per rise_tick.
    - Each fall_tick shifts synchronized SDI into rx_shift.
    - After the 16th fall_tick: rx_sample<=rx_shift, rx_valid pulses, sec_req<=rx_shift[0] -> S_GAP.
  - S_GAP: FSYNC_N=1, SDO=0, counting frame position.
    - At position FRAME_SCLKS/2 with sec_req=1 -> S_SEC.
    - At position FRAME_SCLKS (wrap to 0) -> S_PRI if enable=1 (tx latch as in S_IDLE), else -> S_IDLE.
  - S_SEC: FSYNC_N=0 for 16 periods.
    - SDI word format: bit13 = 1 read / 0 write, bits12:8 = address, bits7:0 = data.
    - SDO bits15:8 = 0.
    - After the 8th fall_tick, the addressed register is loaded into SDO bits7:0, sent in the same frame.
    - After the 16th fall_tick:
      - write: reg[addr]<=data, ctrl_wr pulses, ctrl_addr and ctrl_data update.
      - read: ctrl_addr and ctrl_data update, no ctrl_wr pulse.
    - Then sec_req<=0 -> S_GAP.
- Register file: 32x8, all entries reset to 0 by reset_n only.
- Address 0 is writable and has no special function.

## Timing
- Reset values:
  - SCLK=0, FSYNC_N=1, SDO=0.
  - tx_grasp=0, rx_valid=0, ctrl_wr=0.
  - rx_sample=0, ctrl_addr=0, ctrl_data=0.
  - state S_IDLE.
- tx_grasp fires in the same clk that FSYNC_N falls.
- FSYNC_N stays low for exactly 16 SCLK periods.
- rx_valid and ctrl_wr fire 1 clk after the 16th fall_tick.
- Primary frame period is exactly FRAME_SCLKS*2*SCLK_DIV clks.
- A secondary FSYNC_N fall comes exactly FRAME_SCLKS*SCLK_DIV clks after the primary fall.
- Host margin: with SCLK_DIV≥8, the host's 3-stage input sync and load latency fit inside one half-period.
- Boundary conditions:
  - enable falling mid-frame: the frame completes; any requested secondary frame still runs; then S_IDLE.
  - sync_reset mid-frame: pins return to reset values next clk and the state goes to S_IDLE. rx_valid and ctrl_wr do not fire for the aborted frame.
  - reset_n mid-frame: everything resets, including the register file.
  - sec_req set while a secondary frame is already pending: it has no additional effect. At most one secondary frame per primary frame.

## Structure
- Package si3000_pkg holds:
  - the state enum;
  - localparams for the secondary-word fields: SEC_RW_BIT=13, SEC_ADDR_MSB/LSB=12/8, SEC_DATA_MSB/LSB=7/0;
  - the register count, 32.
- One sub-module, si3000_sclk_gen: divider, SCLK output, rise_tick/fall_tick.
- The FSM, shifters and register file stay in the top module.

## Test plan
- Loopback with the host core, tx_sample=16'hA5C3, host write_data=16'h1234:
  - host read_data=A5C3;
  - rx_sample=1234 with one rx_valid;
  - no secondary frame, since bit0=0.
- Host write_data=16'h0001, then secondary word 16'h0512 (write, addr 5, data 12):
  - secondary FSYNC_N falls FRAME_SCLKS*SCLK_DIV clks after the primary fall;
  - ctrl_wr pulses with ctrl_addr=5, ctrl_data=12.
- Following secondary read word 16'h2500:
  - host read_data[7:0]=12;
  - ctrl_wr stays 0.
- Frame pacing with enable held high for 3 frames:
  - FSYNC_N falls exactly 2*FRAME_SCLKS*SCLK_DIV clks apart;
  - 3 tx_grasp pulses;
  - drop enable, and FSYNC_N stays high after the current frame.
- sync_reset asserted on the 7th SCLK of a primary frame:
  - SCLK=0, FSYNC_N=1 next clk;
  - no rx_valid;
  - the next frame starts cleanly;
  - register 5 still reads 12.
- reset_n pulse mid secondary frame: all outputs at reset values, and register 5 reads 0 afterwards.
